// File: rtl/mux16_arbiter_if.sv
// Handshake bundle for the 16-to-1 gather arbiter: sixteen source channels plus one sink channel.
// The slave modport is the arbiter's view; master is the environment driving sources and the sink.
interface mux16_arbiter_if #(parameter int WIDTH = 64);
  logic [WIDTH-1:0] io_inputs_0;
  logic [WIDTH-1:0] io_inputs_1;
  logic [WIDTH-1:0] io_inputs_2;
  logic [WIDTH-1:0] io_inputs_3;
  logic [WIDTH-1:0] io_inputs_4;
  logic [WIDTH-1:0] io_inputs_5;
  logic [WIDTH-1:0] io_inputs_6;
  logic [WIDTH-1:0] io_inputs_7;
  logic [WIDTH-1:0] io_inputs_8;
  logic [WIDTH-1:0] io_inputs_9;
  logic [WIDTH-1:0] io_inputs_10;
  logic [WIDTH-1:0] io_inputs_11;
  logic [WIDTH-1:0] io_inputs_12;
  logic [WIDTH-1:0] io_inputs_13;
  logic [WIDTH-1:0] io_inputs_14;
  logic [WIDTH-1:0] io_inputs_15;
  logic [15:0]      io_valid;
  logic [15:0]      io_ready;
  logic [WIDTH-1:0] io_output;
  logic [3:0]       io_output_select;
  logic             io_output_valid;
  logic             io_output_ready;

  modport slave (
    input  io_inputs_0, io_inputs_1, io_inputs_2, io_inputs_3,
           io_inputs_4, io_inputs_5, io_inputs_6, io_inputs_7,
           io_inputs_8, io_inputs_9, io_inputs_10, io_inputs_11,
           io_inputs_12, io_inputs_13, io_inputs_14, io_inputs_15,
           io_valid, io_output_ready,
    output io_ready, io_output, io_output_select, io_output_valid
  );

  modport master (
    output io_inputs_0, io_inputs_1, io_inputs_2, io_inputs_3,
           io_inputs_4, io_inputs_5, io_inputs_6, io_inputs_7,
           io_inputs_8, io_inputs_9, io_inputs_10, io_inputs_11,
           io_inputs_12, io_inputs_13, io_inputs_14, io_inputs_15,
           io_valid, io_output_ready,
    input  io_ready, io_output, io_output_select, io_output_valid
  );
endinterface

// File: rtl/mux16_arbiter.sv
// Round-robin 16-to-1 valid/ready merge into one registered output stage; 1-cycle latency.
// Backpressure: sources see io_ready only when the stage is empty or being drained the same cycle.
module mux16_arbiter #(
  parameter int WIDTH = 64
) (
  input logic            clock,
  input logic            reset,
  mux16_arbiter_if.slave bus
);
  logic [WIDTH-1:0] src [16];
  logic [3:0]       ptr;
  logic [3:0]       gnt_idx;
  logic [3:0]       idx;
  logic             found;
  logic             load;
  logic [WIDTH-1:0] out_dat;
  logic [3:0]       out_sel;
  logic             out_vld;

  assign src[0]  = bus.io_inputs_0;
  assign src[1]  = bus.io_inputs_1;
  assign src[2]  = bus.io_inputs_2;
  assign src[3]  = bus.io_inputs_3;
  assign src[4]  = bus.io_inputs_4;
  assign src[5]  = bus.io_inputs_5;
  assign src[6]  = bus.io_inputs_6;
  assign src[7]  = bus.io_inputs_7;
  assign src[8]  = bus.io_inputs_8;
  assign src[9]  = bus.io_inputs_9;
  assign src[10] = bus.io_inputs_10;
  assign src[11] = bus.io_inputs_11;
  assign src[12] = bus.io_inputs_12;
  assign src[13] = bus.io_inputs_13;
  assign src[14] = bus.io_inputs_14;
  assign src[15] = bus.io_inputs_15;

  // Stage can take a word if empty or if the sink drains it on this same edge.
  assign load = !out_vld || bus.io_output_ready;

  // First valid source at or after ptr, wrapping modulo 16.
  always_comb begin
    found   = 1'b0;
    gnt_idx = '0;
    idx     = '0;
    for (int i = 0; i < 16; i++) begin
      idx = ptr + 4'(i);
      if (!found && bus.io_valid[idx]) begin
        found   = 1'b1;
        gnt_idx = idx;
      end
    end
  end

  assign bus.io_ready = (reset && load && found) ? (16'h0001 << gnt_idx) : 16'h0000;

  always_ff @(posedge clock) begin
    if (!reset) begin
      out_vld <= 1'b0;
      out_dat <= '0;
      out_sel <= '0;
      ptr     <= '0;
    end else if (load) begin
      if (found) begin
        out_dat <= src[gnt_idx];
        out_sel <= gnt_idx;
        out_vld <= 1'b1;
        ptr     <= gnt_idx + 4'd1;
      end else begin
        out_vld <= 1'b0;
      end
    end
  end

  assign bus.io_output        = out_dat;
  assign bus.io_output_select = out_sel;
  assign bus.io_output_valid  = out_vld;
endmodule
